conv2d3x3_stream: RTL

- Streaming 3x3 2-D convolution over a raster-scan frame of IMG_W x IMG_H pixels, one pixel per accepted valid_in.
- Integer/fixed-point datapath: signed coefficients, accumulator, arithmetic right shift, clamp to pixel range.
- Nine coefficients are writable at run time through a shadow bank; the shadow bank is committed at frame start.
- Sits between the pixel source (image reader) and the pixel sink (image writer), replacing the fixed-kernel float filter.

---
 rtl/conv2d_pkg.sv | 44 ++++
 rtl/conv_line_buffer.sv | 31 +++
 rtl/conv2d3x3_stream.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/conv2d_pkg.sv
// Shared types, tap indices and arithmetic helpers for the 3x3 streaming
// convolution. The tap layout is row-major, top-left first.
package conv2d_pkg;

  localparam int NTAP = 9;

  localparam int KTL = 0;
  localparam int KT  = 1;
  localparam int KTR = 2;
  localparam int KL  = 3;
  localparam int KC  = 4;
  localparam int KR  = 5;
  localparam int KBL = 6;
  localparam int KB  = 7;
  localparam int KBR = 8;

  // Identity kernel: only the centre tap is one.
  localparam logic [NTAP-1:0] ID_KERNEL = 9'b0_0001_0000;

  function automatic int acc_w(input int coef_w, input int pix_w);
    return coef_w + pix_w + 5;
  endfunction

  function automatic logic signed [47:0] clamp_pix(
    input logic signed [47:0] v,
    input int                 pix_w,
    input logic               abs_en
  );
    logic signed [47:0] a;
    logic signed [47:0] mx;
    logic signed [47:0] r;
    mx = (48'sd1 <<< pix_w) - 48'sd1;
    a  = (abs_en && v < 0) ? -v : v;
    if (a < 0) begin
      r = '0;
    end else if (a > mx) begin
      r = mx;
    end else begin
      r = a;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Enable-gated shift FIFO: dout_o is the sample written DEPTH enables ago.
// Used as a one-row delay line for the convolution window.
module conv_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 100
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (en_i) begin
      mem_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign dout_o = mem_q[DEPTH-1];

endmodule

// File: rtl/conv2d3x3_stream.sv
// Streaming 3x3 convolution with run-time kernel committed at frame start.
// Define CONV2D_ABS_OUT_EN to output |sum| clamped at the top only.
module conv2d3x3_stream
  import conv2d_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100,
  parameter int SHIFT  = 0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              valid_in,
  input  logic [PIX_W-1:0]  data_in,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              valid_out,
  output logic [PIX_W-1:0]  data_out,
  output logic              frame_done
);

  localparam int ACC_W = acc_w(COEF_W, PIX_W);
  localparam int PRD_W = COEF_W + PIX_W + 1;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);

`ifdef CONV2D_ABS_OUT_EN
  localparam logic AbsEn = 1'b1;
`else
  localparam logic AbsEn = 1'b0;
`endif

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          col_last, row_last, sof;

  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign sof      = valid_in && (col_q == '0) && (row_q == '0);

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (valid_in) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  logic signed [COEF_W-1:0] sh_q  [NTAP];
  logic signed [COEF_W-1:0] act_q [NTAP];

  // Commit reads the shadow before this edge's write, so a write on the
  // first pixel of a frame lands in the next frame's kernel.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NTAP; i++) begin
        sh_q[i]  <= ID_KERNEL[i] ? COEF_W'(1) : '0;
        act_q[i] <= ID_KERNEL[i] ? COEF_W'(1) : '0;
      end
    end else begin
      if (sof) begin
        for (int i = 0; i < NTAP; i++) begin
          act_q[i] <= sh_q[i];
        end
      end
      if (coef_we && coef_addr <= 4'd8) begin
        sh_q[coef_addr] <= coef_data;
      end
    end
  end

  logic [PIX_W-1:0] lb0_dout, lb1_dout;

  conv_line_buffer #(
    .DATA_WIDTH (PIX_W),
    .DEPTH      (IMG_W)
  ) u_lb0 (
    .Clk    (Clk),
    .Rst    (Rst),
    .en_i   (valid_in),
    .din_i  (data_in),
    .dout_o (lb0_dout)
  );

  conv_line_buffer #(
    .DATA_WIDTH (PIX_W),
    .DEPTH      (IMG_W)
  ) u_lb1 (
    .Clk    (Clk),
    .Rst    (Rst),
    .en_i   (valid_in),
    .din_i  (lb0_dout),
    .dout_o (lb1_dout)
  );

  logic [PIX_W-1:0] win_q [NTAP];
  logic             q1_q, last1_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NTAP; i++) begin
        win_q[i] <= '0;
      end
      q1_q    <= 1'b0;
      last1_q <= 1'b0;
    end else begin
      q1_q    <= valid_in && (row_q >= RW'(2)) && (col_q >= CW'(2));
      last1_q <= valid_in && row_last && col_last;
      if (valid_in) begin
        win_q[KTL] <= win_q[KT];
        win_q[KT]  <= win_q[KTR];
        win_q[KTR] <= lb1_dout;
        win_q[KL]  <= win_q[KC];
        win_q[KC]  <= win_q[KR];
        win_q[KR]  <= lb0_dout;
        win_q[KBL] <= win_q[KB];
        win_q[KB]  <= win_q[KBR];
        win_q[KBR] <= data_in;
      end
    end
  end

  logic signed [PRD_W-1:0] prod_q [NTAP];
  logic                    q2_q, last2_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < NTAP; i++) begin
        prod_q[i] <= '0;
      end
      q2_q    <= 1'b0;
      last2_q <= 1'b0;
    end else begin
      q2_q    <= q1_q;
      last2_q <= last1_q;
      for (int i = 0; i < NTAP; i++) begin
        prod_q[i] <= PRD_W'(act_q[i]) *
                     PRD_W'($signed({1'b0, win_q[i]}));
      end
    end
  end

  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                    q3_q, last3_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NTAP; i++) begin
      sum_d = sum_d + ACC_W'(prod_q[i]);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sum_q   <= '0;
      q3_q    <= 1'b0;
      last3_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      q3_q    <= q2_q;
      last3_q <= last2_q;
    end
  end

  logic signed [ACC_W-1:0] shr_s;
  logic signed [47:0]      shr_ext;
  logic [PIX_W-1:0]        pix_d;

  assign shr_s   = sum_q >>> SHIFT;
  assign shr_ext = 48'(shr_s);
  assign pix_d   = PIX_W'(clamp_pix(shr_ext, PIX_W, AbsEn));

  logic             vout_q, done_q;
  logic [PIX_W-1:0] dout_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vout_q <= 1'b0;
      done_q <= 1'b0;
      dout_q <= '0;
    end else begin
      vout_q <= q3_q;
      done_q <= q3_q && last3_q;
      if (q3_q) begin
        dout_q <= pix_d;
      end
    end
  end

  assign valid_out  = vout_q;
  assign data_out   = dout_q;
  assign frame_done = done_q;

endmodule
